grid_mover: RTL and testbench

//  Parametrised successor to the Pacman movement/collision pair: one FSM that steps a sprite
//  one pixel per step_tick over a tile map, checks the target tile for walls via a map read

---
 rtl/grid_mover.sv | 203 ++++++++++++++++++++
 tb/tb_grid_mover.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mover.sv
// grid_mover: moves one sprite across a tile map, one pixel per step_tick.
// Each step can first try a queued turn, then tries a forward move. Both use
// the shared map read port. Turns are taken only when the sprite is
// tile-aligned, except for a reversal, which is taken at any pixel. Eaten dots
// and pellets are written back to the map as empty tiles. A power pellet
// starts an invincibility down-counter that is clocked by step_tick.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   enable, step_tick       movement enable and one-cycle movement strobe
//   dir_req, dir_req_valid  requested direction (0 up, 1 down, 2 left, 3 right)
//   init_x, init_y          spawn pixel, loaded on reset
//   map_rd_en, map_rd_data  map read strobe and returned tile
//                           (0 empty, 1 pellet, 2 dot, 3 wall, other values empty)
//   map_addr_x, map_addr_y  tile address, shared by reads and writes
//   map_wr_en, map_wr_data  map write strobe; the written data is always empty
//   pos_x, pos_y, dir       current pixel position and travel direction
//   invincible              power-pellet timer running
//   dot_eaten, pellet_eaten one-cycle collection pulses
//   busy                    a step is in progress
//
// state        | meaning
// S_IDLE       | waiting for enable & step_tick
// S_TURN_RD    | read the tile one pixel away in the pending direction
// S_TURN_WAIT  | wait out the extra read latency
// S_TURN_CHK   | take the turn if that tile is not a wall
// S_FWD_RD     | read the tile one pixel away in the current direction
// S_FWD_WAIT   | wait out the extra read latency
// S_FWD_CHK    | move unless blocked; note any dot or pellet
// S_CLEAR      | write the eaten tile back as empty
module grid_mover #(
  parameter int COORD_W      = 8,
  parameter int TILE_PX      = 5,
  parameter int MAP_W        = 32,
  parameter int MAP_H        = 24,
  parameter int TIDX_W       = 5,
  parameter int RD_LAT       = 1,
  parameter int INVINC_STEPS = 50
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               step_tick,
  input  logic [1:0]         dir_req,
  input  logic               dir_req_valid,
  input  logic [COORD_W-1:0] init_x,
  input  logic [COORD_W-1:0] init_y,
  output logic               map_rd_en,
  output logic [TIDX_W-1:0]  map_addr_x,
  output logic [TIDX_W-1:0]  map_addr_y,
  input  logic [2:0]         map_rd_data,
  output logic               map_wr_en,
  output logic [2:0]         map_wr_data,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         dir,
  output logic               invincible,
  output logic               dot_eaten,
  output logic               pellet_eaten,
  output logic               busy
);

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(MAP_W * TILE_PX - 1);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(MAP_H * TILE_PX - 1);
  localparam logic [COORD_W-1:0] TILE_C = COORD_W'(TILE_PX);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam int TMR_W     = $clog2(INVINC_STEPS + 1);
  localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_TURN_RD, S_TURN_WAIT, S_TURN_CHK,
    S_FWD_RD, S_FWD_WAIT, S_FWD_CHK, S_CLEAR
  } state_t;

  state_t             state, state_n;
  logic               pend_valid;
  logic [1:0]         pend_dir;
  logic [TMR_W-1:0]   timer;
  logic [1:0]         wait_cnt;
  logic [1:0]         test_dir;
  logic [COORD_W-1:0] tgt_x, tgt_y, src_x, src_y;
  logic               aligned, reversal;
  logic               tile_wall, tile_dot, tile_pellet;

  assign tile_wall   = (map_rd_data == 3'd3);
  assign tile_dot    = (map_rd_data == 3'd2);
  assign tile_pellet = (map_rd_data == 3'd1);
  assign aligned     = ((pos_x % TILE_C) == '0) && ((pos_y % TILE_C) == '0);
  // A reversal flips bit 0 and keeps the axis bit.
  assign reversal    = (pend_dir == {dir[1], ~dir[0]});

  assign test_dir = (state == S_TURN_RD || state == S_TURN_WAIT || state == S_TURN_CHK)
                    ? pend_dir : dir;

  always_comb begin
    tgt_x = pos_x;
    tgt_y = pos_y;
    case (test_dir)
      2'd0:    tgt_y = (pos_y == '0)    ? Y_MAX : pos_y - ONE;
      2'd1:    tgt_y = (pos_y == Y_MAX) ? '0    : pos_y + ONE;
      2'd2:    tgt_x = (pos_x == '0)    ? X_MAX : pos_x - ONE;
      default: tgt_x = (pos_x == X_MAX) ? '0    : pos_x + ONE;
    endcase
  end

  // The write-back happens after pos has moved onto the eaten tile.
  assign src_x      = (state == S_CLEAR) ? pos_x : tgt_x;
  assign src_y      = (state == S_CLEAR) ? pos_y : tgt_y;
  assign map_addr_x = TIDX_W'(src_x / TILE_C);
  assign map_addr_y = TIDX_W'(src_y / TILE_C);
  assign map_wr_data = 3'd0;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    map_rd_en = 1'b0;
    map_wr_en = 1'b0;
    case (state)
      S_IDLE:
        if (enable && step_tick)
          state_n = (pend_valid && (aligned || reversal)) ? S_TURN_RD : S_FWD_RD;
      S_TURN_RD: begin
        map_rd_en = !reset;
        state_n   = (RD_LAT > 1) ? S_TURN_WAIT : S_TURN_CHK;
      end
      S_TURN_WAIT: if (wait_cnt == 2'd0) state_n = S_TURN_CHK;
      S_TURN_CHK:  state_n = S_FWD_RD;
      S_FWD_RD: begin
        map_rd_en = !reset;
        state_n   = (RD_LAT > 1) ? S_FWD_WAIT : S_FWD_CHK;
      end
      S_FWD_WAIT: if (wait_cnt == 2'd0) state_n = S_FWD_CHK;
      S_FWD_CHK:
        state_n = (!tile_wall && (tile_dot || tile_pellet)) ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        // Gated so that a reset in this cycle issues no write.
        map_wr_en = !reset;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x        <= init_x;
      pos_y        <= init_y;
      dir          <= 2'd0;
      pend_valid   <= 1'b0;
      pend_dir     <= 2'd0;
      timer        <= '0;
      invincible   <= 1'b0;
      dot_eaten    <= 1'b0;
      pellet_eaten <= 1'b0;
      wait_cnt     <= 2'd0;
    end else begin
      dot_eaten    <= 1'b0;
      pellet_eaten <= 1'b0;

      if (state == S_TURN_RD || state == S_FWD_RD)
        wait_cnt <= 2'(WAIT_INIT);
      else if (state == S_TURN_WAIT || state == S_FWD_WAIT)
        wait_cnt <= wait_cnt - 2'd1;

      if (state == S_TURN_CHK && !tile_wall) begin
        dir        <= pend_dir;
        pend_valid <= 1'b0;
      end

      // A new request is placed after the turn commit, so it wins a tie.
      if (dir_req_valid) begin
        if (dir_req == dir) begin
          pend_valid <= 1'b0;
        end else begin
          pend_valid <= 1'b1;
          pend_dir   <= dir_req;
        end
      end

      if (state == S_FWD_CHK && !tile_wall) begin
        pos_x        <= tgt_x;
        pos_y        <= tgt_y;
        dot_eaten    <= tile_dot;
        pellet_eaten <= tile_pellet;
      end

      // A pellet reload takes precedence over expiry in the same cycle.
      if (state == S_FWD_CHK && tile_pellet) begin
        timer      <= TMR_W'(INVINC_STEPS);
        invincible <= 1'b1;
      end else if (step_tick && timer != '0) begin
        timer <= timer - TMR_W'(1);
        if (timer == TMR_W'(1)) invincible <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
module tb_grid_mover;

  localparam int COORD_W = 8;
  localparam int TILE_PX = 5;
  localparam int MAP_W   = 32;
  localparam int MAP_H   = 24;
  localparam int TIDX_W  = 5;
  localparam int RD_LAT  = 2;
  localparam int INVINC  = 50;

  logic               clock, reset, enable, step_tick;
  logic [1:0]         dir_req;
  logic               dir_req_valid;
  logic [COORD_W-1:0] init_x, init_y;
  logic               map_rd_en, map_wr_en;
  logic [TIDX_W-1:0]  map_addr_x, map_addr_y;
  logic [2:0]         map_rd_data, map_wr_data;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [1:0]         dir;
  logic               invincible, dot_eaten, pellet_eaten, busy;

  grid_mover #(
    .COORD_W(COORD_W), .TILE_PX(TILE_PX), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .TIDX_W(TIDX_W), .RD_LAT(RD_LAT), .INVINC_STEPS(INVINC)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .step_tick(step_tick),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .init_x(init_x), .init_y(init_y),
    .map_rd_en(map_rd_en), .map_addr_x(map_addr_x), .map_addr_y(map_addr_y),
    .map_rd_data(map_rd_data), .map_wr_en(map_wr_en), .map_wr_data(map_wr_data),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .invincible(invincible),
    .dot_eaten(dot_eaten), .pellet_eaten(pellet_eaten), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Map model: written only by the stimulus process, read with RD_LAT latency.
  logic [2:0] map_mem [0:31][0:31];
  logic [2:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clock) begin
    rd_pipe[0] <= map_mem[map_addr_y][map_addr_x];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign map_rd_data = rd_pipe[RD_LAT-1];

  // Output monitor: counts strobes/pulses and logs writes as {x, y, data}.
  int rd_cnt = 0;
  int wr_cnt = 0;
  int dot_cnt = 0;
  int pel_cnt = 0;
  logic [12:0] wr_log [0:255];
  always @(negedge clock) begin
    if (map_rd_en) rd_cnt <= rd_cnt + 1;
    if (dot_eaten) dot_cnt <= dot_cnt + 1;
    if (pellet_eaten) pel_cnt <= pel_cnt + 1;
    if (map_wr_en) begin
      wr_log[wr_cnt[7:0]] <= {map_addr_x, map_addr_y, map_wr_data};
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int wr_rd = 0;
  logic [12:0] exp_wr [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(output int cyc);
    @(negedge clock) step_tick = 1'b1;
    @(negedge clock) step_tick = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clock);
    end
    chk("step_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic ticks(input int n);
    int c;
    for (int i = 0; i < n; i++) tick(c);
  endtask

  task automatic req(input logic [1:0] d);
    @(negedge clock);
    dir_req = d;
    dir_req_valid = 1'b1;
    @(negedge clock) dir_req_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] x, input logic [7:0] y);
    @(negedge clock);
    init_x = x;
    init_y = y;
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  // Pop every expected write and match it to the next logged write.
  task automatic check_writes();
    logic [12:0] e;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (wr_rd < wr_cnt) begin
        chk("wr_entry", {19'd0, wr_log[wr_rd[7:0]]}, {19'd0, e});
        map_mem[e[7:3]][e[12:8]] = 3'd0;
        wr_rd++;
      end else begin
        chk("wr_missing", wr_cnt, wr_rd + 1);
      end
    end
    chk("wr_extra", wr_cnt, wr_rd);
    wr_rd = wr_cnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, r0, d0, p0, w0;
    reset = 1'b1; enable = 1'b1; step_tick = 1'b0;
    dir_req = 2'd0; dir_req_valid = 1'b0; init_x = 8'd10; init_y = 8'd10;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) map_mem[y][x] = 3'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_pos_x", pos_x, 10);
    chk("rst_pos_y", pos_y, 10);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inv", invincible, 0);

    // Turn right at an aligned pixel, then three steps on an empty map.
    req(2'd3);
    r0 = rd_cnt;
    tick(cyc);
    chk("t1_turn_cycles", cyc, 2 * (RD_LAT + 1));
    ticks(2);
    chk("t1_pos_x", pos_x, 13);
    chk("t1_pos_y", pos_y, 10);
    chk("t1_dir", dir, 3);
    chk("t1_reads", rd_cnt - r0, 4);
    check_writes();

    // Blocked by a wall at tile (3,2).
    ticks(1);
    map_mem[2][3] = 3'd3;
    tick(cyc);
    chk("t2_pos_x", pos_x, 14);
    chk("t2_pos_y", pos_y, 10);
    chk("t2_cycles", cyc, RD_LAT + 1);

    // Dot at tile (3,2).
    map_mem[2][3] = 3'd2;
    d0 = dot_cnt;
    exp_wr.push_back({5'd3, 5'd2, 3'd0});
    tick(cyc);
    chk("t4_pos_x", pos_x, 15);
    chk("t4_dot_cycles", dot_cnt - d0, 1);
    chk("t4_cycles", cyc, RD_LAT + 2);
    check_writes();

    // A request equal to dir clears the pending turn.
    req(2'd0);
    req(2'd3);
    r0 = rd_cnt;
    tick(cyc);
    chk("clr_reads", rd_cnt - r0, 1);
    chk("clr_dir", dir, 3);
    chk("clr_pos_x", pos_x, 16);

    // enable low: ticks are ignored.
    enable = 1'b0;
    r0 = rd_cnt;
    tick(cyc);
    chk("en_reads", rd_cnt - r0, 0);
    chk("en_pos_x", pos_x, 16);
    chk("en_cycles", cyc, 0);
    enable = 1'b1;

    // Reversal at an unaligned pixel, then a blocked turn held pending.
    do_reset(8'd10, 8'd6);
    req(2'd1);
    tick(cyc);
    chk("t3_rev_dir", dir, 1);
    chk("t3_rev_y", pos_y, 7);
    ticks(3);
    chk("t3_y10", pos_y, 10);
    map_mem[1][2] = 3'd3;
    req(2'd0);
    r0 = rd_cnt;
    tick(cyc);
    chk("t3_blk_dir", dir, 1);
    chk("t3_blk_y", pos_y, 11);
    chk("t3_blk_reads", rd_cnt - r0, 2);
    map_mem[1][2] = 3'd0;
    tick(cyc);
    chk("t3_turn_dir", dir, 0);
    chk("t3_turn_y", pos_y, 10);
    chk("t3_turn_cycles", cyc, 2 * (RD_LAT + 1));
    ticks(1);
    chk("t3_y9", pos_y, 9);
    check_writes();

    // Power pellet, then a reload at the 49th tick of invincibility.
    do_reset(8'd0, 8'd50);
    map_mem[10][1] = 3'd1;
    req(2'd3);
    ticks(4);
    chk("t5_pre_x", pos_x, 4);
    chk("t5_pre_inv", invincible, 0);
    p0 = pel_cnt;
    exp_wr.push_back({5'd1, 5'd10, 3'd0});
    ticks(1);
    check_writes();
    chk("t5_inv_on", invincible, 1);
    ticks(48);
    chk("t5_inv_48", invincible, 1);
    chk("t5_x53", pos_x, 53);
    map_mem[10][10] = 3'd1;
    exp_wr.push_back({5'd10, 5'd10, 3'd0});
    ticks(1);
    check_writes();
    chk("t5_reload_inv", invincible, 1);
    ticks(49);
    chk("t5_inv_49", invincible, 1);
    ticks(1);
    chk("t5_inv_50", invincible, 0);
    chk("t5_pellets", pel_cnt - p0, 2);

    // Wrap-around on both axes.
    do_reset(8'd0, 8'd50);
    req(2'd2);
    ticks(1);
    chk("wrap_x", pos_x, 159);
    chk("wrap_dir", dir, 2);
    do_reset(8'd10, 8'd0);
    ticks(1);
    chk("wrap_y", pos_y, 119);

    // Reset while waiting on a read of a dot tile: no write, back to init.
    do_reset(8'd20, 8'd30);
    map_mem[5][4] = 3'd2;
    w0 = wr_cnt;
    d0 = dot_cnt;
    @(negedge clock) step_tick = 1'b1;
    @(negedge clock) step_tick = 1'b0;
    @(negedge clock);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("mid_pos_x", pos_x, 20);
    chk("mid_pos_y", pos_y, 30);
    chk("mid_writes", wr_cnt - w0, 0);
    chk("mid_dots", dot_cnt - d0, 0);
    chk("mid_idle", busy, 0);
    map_mem[5][4] = 3'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
